ifmap_stream_writer: RTL and testbench
======================================

Name: ifmap_stream_writer

Overview:
- Producer side of the IF-map FIFO: accepts raw pixels from the host one per handshake and tags each with a row start/end flag.
- Packs IF_PAR_WRITE tagged words into one wide word and writes it into the IF-map Fifo_buffer, honouring its full flag.
- Its output is exactly the tagged word stream the IF read controller decodes: start flag at bit IF_WIDTH-1, end flag at bit IF_WIDTH-2.

Parameters:
- IF_WIDTH, 16, tagged word width; pixel payload is IF_WIDTH-2 bits.
- IF_PAR_WRITE, 12, words per FIFO write (lanes).
- ROW_LEN_WIDTH, 8, width of row_len config.
- ROWS_WIDTH, 8, width of num_rows config.
- LANE_WIDTH, (IF_PAR_WRITE>1)?$clog2(IF_PAR_WRITE):1, lane index width (local).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; latches row_len/num_rows and begins a frame.
- row_len  in  ROW_LEN_WIDTH  pixels per row.
- num_rows  in  ROWS_WIDTH  rows per frame.
- pix_in  in  IF_WIDTH-2  pixel payload.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- fifo_din  out  IF_WIDTH*IF_PAR_WRITE  packed tagged words; lane 0 = bits [IF_WIDTH-1:0].
- fifo_wen  out  1  write strobe to the IF FIFO.
- fifo_full  in  1  IF FIFO full.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last FIFO write of a frame.

Behaviour:
- Reset (async, mid-frame included): state IDLE; all counters, pack register and fifo_din cleared to 0; pix_ready=0, fifo_wen=0, busy=0, done=0.
- States:
  - IDLE: start=1 latches config.
    - row_len==0 or num_rows==0 -> DONE, with no writes.
    - otherwise -> FILL.
  - FILL: pix_ready=1.
    - Accept when pix_valid && pix_ready.
    - Tag per pixel: start = (col==0); end = (col==row_len-1). row_len==1 gives tag 2'b11.
    - Word {start,end,pix_in} stored at current lane; col, row and lane advance.
    - When lane IF_PAR_WRITE-1 is filled, or the last pixel of the frame (row==num_rows-1 && col==row_len-1) is accepted -> WRITE.
  - WRITE: pix_ready=0; fifo_din holds pack.
    - fifo_wen=1 exactly in the cycle fifo_full==0; the write occurs at that edge. Stalls indefinitely while full.
    - After the write: pack cleared, lane=0, then -> FILL, or -> DONE if the frame's last pixel was in this pack.
  - DONE: done=1 for one cycle, busy=0 in that cycle -> IDLE.
- busy=1 in FILL and WRITE.
- start is ignored outside IDLE; config changes mid-frame have no effect.
- Partial final pack: unfilled lanes are all-zero words (tags 2'b00); the reader discards words outside start/end brackets.
- Latency: the edge accepting the pack-completing pixel is followed by fifo_wen in the next cycle if not full. Minimum one bubble per pack; throughput is IF_PAR_WRITE pixels per IF_PAR_WRITE+1 cycles.
- Counters: col wraps to 0 at row_len-1, and row increments at that point. Lane wraps to 0 only via a write.
- fifo_wen is never asserted while fifo_full=1.
- pix_valid is ignored when pix_ready=0; the host holds data.

Optional Feature:
- Macro IFMAP_STREAM_WRITER_FLUSH_EN.
- Defined: adds input flush (1 bit). flush=1 in FILL with lane!=0 forces -> WRITE of the partial pack (zero padded). Rows continue normally afterwards; flush with lane==0 or outside FILL is ignored.
- Undefined: no flush port; a partial pack is written only at frame end.

Decomposition:
- Shared package: state encoding (IDLE, FILL, WRITE, DONE), tag bit positions (START_BIT=IF_WIDTH-1, END_BIT=IF_WIDTH-2), lane-width function.
- One natural sub-module: ifmap_tag_gen (col/row counters producing start/end tags and the last-pixel flag). Packing and FSM stay in the top.

Test Plan:
- IF_PAR_WRITE=4, row_len=3, num_rows=2, pixels 1..6, full=0 -> two writes:
  - lane tags 10,00,01,10 with data 1,2,3,4;
  - then 00,01,00(0),00(0) with data 5,6,0,0;
  - done pulses 1 cycle after the 2nd write.
- Same frame, fifo_full=1 for 5 cycles at the first WRITE -> fifo_wen held 0, pix_ready 0, fifo_din stable; write on the first cycle full drops; output unchanged otherwise.
- row_len=1, num_rows=4, IF_PAR_WRITE=4 -> single write with all four lanes tagged 11.
- start with row_len=0 -> no fifo_wen, done pulse 1 cycle after start, busy never 1.
- rst asserted after 2 accepted pixels -> outputs 0 immediately (asynchronous); restart frame produces correct tags from col 0.
- FLUSH_EN: flush after 2 pixels of row_len=8 -> one write with lanes {10,p0},{00,p1},0,0; next pixel lands in lane 0 with tag 00.

Source files
------------

// File: rtl/ifmap_stream_writer_pkg.sv
// ifmap_stream_writer_pkg
//   Shared definitions for the IF-map stream writer.
//   - state_t : writer FSM encoding (IDLE, FILL, WRITE, DONE)
//   - start_bit / end_bit : tag bit positions within a tagged word
//   - lane_w  : lane-index width for a given pack size (min 1 bit)
package ifmap_stream_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Tagged word layout: {start, end, payload[w-3:0]}
  function automatic int start_bit(input int w);
    return w - 1;
  endfunction

  function automatic int end_bit(input int w);
    return w - 2;
  endfunction

  function automatic int lane_w(input int par);
    return (par > 1) ? $clog2(par) : 1;
  endfunction

endpackage

// File: rtl/ifmap_stream_writer_tag_gen.sv
// ifmap_tag_gen
//   Column/row position tracker for the pixel stream. Produces the row
//   start/end tags for the pixel currently offered and flags the last pixel
//   of the frame.
//   Ports:
//     clk, rst         clock, async active-high reset
//     clear            restart counters at col 0 / row 0 (frame start)
//     adv              a pixel was accepted this cycle
//     row_len,num_rows latched frame geometry
//     tag_start        current pixel is column 0
//     tag_end          current pixel is column row_len-1
//     last_pix         current pixel is the final pixel of the frame
module ifmap_tag_gen #(
  parameter int ROW_LEN_WIDTH = 8,
  parameter int ROWS_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     adv,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROWS_WIDTH-1:0]    num_rows,
  output logic                     tag_start,
  output logic                     tag_end,
  output logic                     last_pix
);

  logic [ROW_LEN_WIDTH-1:0] col;
  logic [ROWS_WIDTH-1:0]    row;
  logic                     col_last;

  assign col_last  = (col == row_len - 1'b1);
  assign tag_start = (col == '0);
  assign tag_end   = col_last;
  assign last_pix  = col_last && (row == num_rows - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifmap_stream_writer.sv
// ifmap_stream_writer
//   Producer side of the IF-map FIFO. Accepts host pixels one per
//   handshake, tags each with row start/end flags, packs IF_PAR_WRITE
//   tagged words per FIFO write and honours the FIFO full flag.
//   Ports:
//     clk, rst            clock, async active-high reset
//     start               begin a frame (latches row_len / num_rows)
//     row_len, num_rows   frame geometry
//     pix_in, pix_valid   pixel payload and valid
//     pix_ready           pixel accepted this cycle when valid
//     fifo_din            packed tagged words, lane 0 in the low bits
//     fifo_wen            FIFO write strobe (never while fifo_full)
//     fifo_full           FIFO full
//     busy                frame in progress (FILL or WRITE)
//     done                one-cycle pulse after the last write of a frame
//     flush               (IFMAP_STREAM_WRITER_FLUSH_EN only) write out a
//                         partial pack early
//   Optional feature macro: IFMAP_STREAM_WRITER_FLUSH_EN
module ifmap_stream_writer
  import ifmap_stream_writer_pkg::*;
#(
  parameter int IF_WIDTH      = 16,
  parameter int IF_PAR_WRITE  = 12,
  parameter int ROW_LEN_WIDTH = 8,
  parameter int ROWS_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ROW_LEN_WIDTH-1:0]         row_len,
  input  logic [ROWS_WIDTH-1:0]            num_rows,
  input  logic [IF_WIDTH-3:0]              pix_in,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  output logic [IF_WIDTH*IF_PAR_WRITE-1:0] fifo_din,
`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
  input  logic                             flush,
`endif
  output logic                             fifo_wen,
  input  logic                             fifo_full,
  output logic                             busy,
  output logic                             done
);

  localparam int LANE_WIDTH = lane_w(IF_PAR_WRITE);
  localparam int START_BIT  = start_bit(IF_WIDTH);
  localparam int END_BIT    = end_bit(IF_WIDTH);
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(IF_PAR_WRITE - 1);

  state_t state, state_nx;

  logic [ROW_LEN_WIDTH-1:0]                  cfg_row_len;
  logic [ROWS_WIDTH-1:0]                     cfg_num_rows;
  logic [LANE_WIDTH-1:0]                     lane;
  logic [IF_PAR_WRITE-1:0][IF_WIDTH-1:0]     pack;
  logic                                      last_in_pack;

  logic          accept;
  logic          tag_start, tag_end, last_pix;
  logic          cfg_load;
  logic          cfg_empty;
  logic          do_flush;
  logic [IF_WIDTH-1:0] word;

  assign cfg_load  = (state == S_IDLE) && start;
  assign cfg_empty = (row_len == '0) || (num_rows == '0);
  assign accept    = pix_ready && pix_valid;

`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
  // Flush only matters when the pack holds something.
  assign do_flush = (state == S_FILL) && flush && (lane != '0);
`else
  assign do_flush = 1'b0;
`endif

  ifmap_tag_gen #(
    .ROW_LEN_WIDTH (ROW_LEN_WIDTH),
    .ROWS_WIDTH    (ROWS_WIDTH)
  ) u_tag_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_load),
    .adv       (accept),
    .row_len   (cfg_row_len),
    .num_rows  (cfg_num_rows),
    .tag_start (tag_start),
    .tag_end   (tag_end),
    .last_pix  (last_pix)
  );

  always_comb begin
    word                  = '0;
    word[START_BIT]       = tag_start;
    word[END_BIT]         = tag_end;
    word[IF_WIDTH-3:0]    = pix_in;
  end

  // Next state and outputs
  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    fifo_wen  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = cfg_empty ? S_DONE : S_FILL;
      end
      S_FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (accept && ((lane == LAST_LANE) || last_pix)) state_nx = S_WRITE;
        else if (do_flush)                               state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (!fifo_full) begin
          fifo_wen = 1'b1;
          state_nx = last_in_pack ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cfg_row_len  <= '0;
      cfg_num_rows <= '0;
      lane         <= '0;
      pack         <= '0;
      last_in_pack <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_load) begin
        cfg_row_len  <= row_len;
        cfg_num_rows <= num_rows;
      end
      if (state == S_FILL && accept) begin
        pack[lane] <= word;
        // Lane only returns to 0 through a write, so overflow past the
        // last lane is never observed.
        lane <= lane + 1'b1;
        if (last_pix) last_in_pack <= 1'b1;
      end
      if (state == S_WRITE && !fifo_full) begin
        pack         <= '0;
        lane         <= '0;
        last_in_pack <= 1'b0;
      end
    end
  end

  // The pack register is the write data; unfilled lanes stay zero.
  assign fifo_din = pack;

endmodule

// File: tb/tb_ifmap_stream_writer.sv
module tb_ifmap_stream_writer;
  localparam int W = 16, PAR = 4, RLW = 8, RW = 8, PW = W - 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [RLW-1:0] row_len = '0;
  logic [RW-1:0]  num_rows = '0;
  logic [PW-1:0]  pix_in = '0;
  logic pix_valid = 1'b0, pix_ready;
  logic [W*PAR-1:0] fifo_din;
  logic fifo_wen, fifo_full = 1'b0, busy, done;
`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
  logic flush = 1'b0;
`endif

  ifmap_stream_writer #(
    .IF_WIDTH(W), .IF_PAR_WRITE(PAR), .ROW_LEN_WIDTH(RLW), .ROWS_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .fifo_din(fifo_din),
`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
    .flush(flush),
`endif
    .fifo_wen(fifo_wen), .fifo_full(fifo_full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W*PAR-1:0] exp_q[$];
  logic [PW-1:0]    pix_q[$];
  bit zero_pending = 0;
  int done_cnt = 0;
  bit prev_wen = 0;
  int full_mode = 0, full_pct = 0;
  bit full_force = 0;

  task automatic chk(input string nm, input logic [W*PAR-1:0] act, input logic [W*PAR-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // FIFO full source: random, or forced by a directed test
  always @(posedge clk) begin
    #1;
    if (full_mode == 1) fifo_full = full_force;
    else                fifo_full = (int'($urandom_range(99)) < full_pct);
  end

  // Monitor: pop expected packs on each write; check done placement
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wen) begin
        chk("wen_while_full", fifo_full, 1'b0);
        if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else chk("fifo_din", fifo_din, exp_q.pop_front());
      end
      if (done) begin
        chk("done_busy", busy, 1'b0);
        if (zero_pending) begin
          zero_pending = 0;
          chk("done_zero_frame_no_wen", prev_wen, 1'b0);
        end else begin
          chk("done_after_last_write", {prev_wen, exp_q.size() == 0}, 2'b11);
        end
        done_cnt++;
      end
      prev_wen = fifo_wen;
    end else begin
      prev_wen = 1'b0;
    end
  end

  // Reference model: tags from pixel index, packs of PAR, zero padding
  task automatic build_frame(input int rl, input int nr, input bit seq, input int flush_at);
    logic [W*PAR-1:0] cur;
    logic [W-1:0] wd;
    int ln, n, col;
    pix_q.delete();
    n = rl * nr;
    for (int i = 0; i < n; i++) pix_q.push_back(seq ? PW'(i + 1) : PW'($urandom));
    cur = '0; ln = 0;
    for (int i = 0; i < n; i++) begin
      col = i % rl;
      wd = {col == 0, col == rl - 1, pix_q[i]};
      cur[ln*W +: W] = wd;
      ln++;
      if (ln == PAR || i == n - 1 || i == flush_at) begin
        exp_q.push_back(cur);
        cur = '0; ln = 0;
      end
    end
    if (n == 0) zero_pending = 1;
  endtask

  task automatic start_frame(input int rl, input int nr);
    @(posedge clk); #1;
    start = 1; row_len = RLW'(rl); num_rows = RW'(nr);
    @(posedge clk); #1;
    start = 0; row_len = RLW'($urandom); num_rows = RW'($urandom);
  endtask

  task automatic drive_pixels(input int from, input int to, input int flush_at, input int vpct);
    int idx, cyc;
    bit flush_now;
    idx = from; cyc = 0; flush_now = 0;
    while (idx < to && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = ($urandom_range(9) == 0);  // must be ignored mid-frame
`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
      flush = 0;
      if (flush_now) begin
        flush = 1; pix_valid = 0; flush_now = 0;
      end else
`endif
      begin
        pix_valid = (int'($urandom_range(99)) < vpct);
        pix_in = pix_q[idx];
      end
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        if (idx == flush_at) flush_now = 1;
        idx++;
      end
    end
    if (idx < to) chk("pixel_accept_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    pix_valid = 0; start = 0;
`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
    flush = 0;
`endif
  endtask

  task automatic wait_done(input int target);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < 500) begin
      @(posedge clk); cyc++;
    end
    if (done_cnt < target) chk("done_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int tgt, rl, nr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_fifo_wen", fifo_wen, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fifo_din", fifo_din, '0);
    @(posedge clk); #1 rst = 0;

    // Basic frame, pixels 1..6, no back-pressure
    build_frame(3, 2, 1, -1);
    tgt = done_cnt + 1;
    start_frame(3, 2);
    drive_pixels(0, 6, -1, 100);
    wait_done(tgt);

    // Full held during first WRITE
    full_mode = 1; full_force = 1;
    build_frame(3, 2, 1, -1);
    tgt = done_cnt + 1;
    start_frame(3, 2);
    drive_pixels(0, 4, -1, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_wen", fifo_wen, 1'b0);
      chk("stall_ready", pix_ready, 1'b0);
      chk("stall_din", fifo_din, exp_q[0]);
    end
    full_force = 0;
    drive_pixels(4, 6, -1, 100);
    wait_done(tgt);
    full_mode = 0;

    // row_len=1: every word tagged 11
    build_frame(1, 4, 1, -1);
    tgt = done_cnt + 1;
    start_frame(1, 4);
    drive_pixels(0, 4, -1, 100);
    wait_done(tgt);

    // Empty frame
    build_frame(0, 3, 1, -1);
    start_frame(0, 3);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    @(negedge clk);
    chk("zero_done_once", done, 1'b0);
    chk("zero_busy_after", busy, 1'b0);

    // Asynchronous reset mid-frame, then a clean restart
    build_frame(4, 2, 0, -1);
    start_frame(4, 2);
    drive_pixels(0, 2, -1, 100);
    #2 rst = 1;
    #1;
    chk("arst_pix_ready", pix_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_fifo_din", fifo_din, '0);
    chk("arst_fifo_wen", fifo_wen, 1'b0);
    exp_q.delete(); zero_pending = 0;
    @(posedge clk); #1 rst = 0;
    build_frame(4, 2, 0, -1);
    tgt = done_cnt + 1;
    start_frame(4, 2);
    drive_pixels(0, 8, -1, 100);
    wait_done(tgt);

`ifdef IFMAP_STREAM_WRITER_FLUSH_EN
    // Flush after two pixels of an 8-pixel row
    build_frame(8, 1, 0, 1);
    tgt = done_cnt + 1;
    start_frame(8, 1);
    drive_pixels(0, 8, 1, 100);
    wait_done(tgt);
`endif

    // Randomized frames with back-pressure and valid gaps
    full_pct = 30;
    for (int f = 0; f < 8; f++) begin
      rl = int'($urandom_range(7, 1));
      nr = int'($urandom_range(4, 1));
      build_frame(rl, nr, 0, -1);
      tgt = done_cnt + 1;
      start_frame(rl, nr);
      drive_pixels(0, rl * nr, -1, 70);
      wait_done(tgt);
    end
    full_pct = 0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
